// File: rtl/sram_arbiter_pkg.sv
// Shared types and helpers for the SP SRAM arbiter: FSM encodings, owner one-hot
// constants and the priority/saturation helper functions.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_STATE_IDLE     = 2'd0,
    ARB_STATE_BURST    = 2'd1,
    ARB_STATE_COOLDOWN = 2'd2
  } arb_state_e;

  localparam logic [1:0] ARB_OWN_CPU  = 2'b01;
  localparam logic [1:0] ARB_OWN_DMA  = 2'b10;
  localparam logic [1:0] ARB_OWN_NONE = 2'b00;

  // CTL-first pick; a fired starvation guard moves a requesting DMA ahead.
  function automatic logic [1:0] idle_pick(input logic cpu_req,
                                           input logic dma_req,
                                           input logic starve_fire);
    logic [1:0] pick;
    if (dma_req && starve_fire) begin
      pick = ARB_OWN_DMA;
    end else if (cpu_req) begin
      pick = ARB_OWN_CPU;
    end else if (dma_req) begin
      pick = ARB_OWN_DMA;
    end else begin
      pick = ARB_OWN_NONE;
    end
    return pick;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt, input logic [7:0] max);
    logic [7:0] nxt;
    if (cnt >= max) begin
      nxt = max;
    end else begin
      nxt = cnt + 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sram_arb_req_mux.sv
// Combinational SRAM port mux: routes the granted requester's address, data and
// write enable to the SRAM; drives zeros when nobody holds the grant.
module sram_arb_req_mux
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic [1:0]        gnt,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_di,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_di,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_di,
  output logic              sram_we
);

  // Select the port qualifiers of the one-hot grant owner.
  always_comb begin
    sram_addr = {ADDR_W{1'b0}};
    sram_di   = {DATA_W{1'b0}};
    sram_we   = 1'b0;
    case (gnt)
      ARB_OWN_CPU: begin
        sram_addr = cpu_addr;
        sram_di   = cpu_di;
        sram_we   = cpu_we;
      end
      ARB_OWN_DMA: begin
        sram_addr = dma_addr;
        sram_di   = dma_di;
        sram_we   = dma_we;
      end
      default: begin
        sram_addr = {ADDR_W{1'b0}};
        sram_di   = {DATA_W{1'b0}};
        sram_we   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// CTL/DMA arbiter for the single-port SP SRAM with locked DMA bursts and read-owner
// tracking. Optional DMA starvation guard enabled by defining SRAM_ARB_STARVE_EN.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_di,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_do,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_di,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_do,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  output logic              sram_EN,
  output logic              sram_WE,
  input  logic [DATA_W-1:0] sram_DO
);

  if (MAX_BURST < 1 || MAX_BURST > 255 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_param
    $error("sram_arbiter: MAX_BURST and STARVE_MAX must be within 1..255");
  end

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  arb_state_e state_r;
  logic [7:0] burst_cnt_r;
  logic [1:0] rd_owner_r;
  logic [1:0] gnt_s;
  logic       starve_fire_s;

`ifdef SRAM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);
  logic [7:0] starve_cnt_r;

  // Count consecutive denied DMA request cycles, saturating at the threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 8'd0;
    end else if (!dma_req || gnt_s[1]) begin
      starve_cnt_r <= 8'd0;
    end else begin
      starve_cnt_r <= sat_inc8(starve_cnt_r, STARVE_MAX_C);
    end
  end

  assign starve_fire_s = (starve_cnt_r == STARVE_MAX_C);
`else
  assign starve_fire_s = 1'b0;
`endif

  // Grant decision; a locked burst request bypasses the normal priority rules.
  always_comb begin
    gnt_s = ARB_OWN_NONE;
    if (reset) begin
      gnt_s = ARB_OWN_NONE;
    end else begin
      case (state_r)
        ARB_STATE_BURST: begin
          if (dma_req && dma_lock) begin
            gnt_s = ARB_OWN_DMA;
          end else begin
            gnt_s = idle_pick(cpu_req, dma_req, starve_fire_s);
          end
        end
        ARB_STATE_COOLDOWN: gnt_s = idle_pick(cpu_req, dma_req, 1'b0);
        default:            gnt_s = idle_pick(cpu_req, dma_req, starve_fire_s);
      endcase
    end
  end

  // Burst FSM and burst length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ARB_STATE_IDLE;
      burst_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ARB_STATE_IDLE: begin
          if (gnt_s[1] && dma_lock) begin
            burst_cnt_r <= 8'd1;
            state_r     <= (MAX_BURST_C == 8'd1) ? ARB_STATE_COOLDOWN : ARB_STATE_BURST;
          end
        end
        ARB_STATE_BURST: begin
          if (dma_req && dma_lock) begin
            burst_cnt_r <= sat_inc8(burst_cnt_r, MAX_BURST_C);
            if (({1'b0, burst_cnt_r} + 9'd1) >= {1'b0, MAX_BURST_C}) begin
              state_r <= ARB_STATE_COOLDOWN;
            end
          end else begin
            state_r <= ARB_STATE_COOLDOWN;
          end
        end
        ARB_STATE_COOLDOWN: begin
          burst_cnt_r <= 8'd0;
          state_r     <= ARB_STATE_IDLE;
        end
        default: begin
          burst_cnt_r <= 8'd0;
          state_r     <= ARB_STATE_IDLE;
        end
      endcase
    end
  end

  // Remember who owns the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_r <= ARB_OWN_NONE;
    end else begin
      rd_owner_r <= {gnt_s[1] & ~dma_we, gnt_s[0] & ~cpu_we};
    end
  end

  sram_arb_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_req_mux (
    .gnt      (gnt_s),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_di   (cpu_di),
    .dma_we   (dma_we),
    .dma_addr (dma_addr),
    .dma_di   (dma_di),
    .sram_addr(sram_ADDR),
    .sram_di  (sram_DI),
    .sram_we  (sram_WE)
  );

  assign cpu_gnt    = gnt_s[0];
  assign dma_gnt    = gnt_s[1];
  assign sram_EN    = gnt_s[0] | gnt_s[1];
  assign cpu_rvalid = rd_owner_r[0];
  assign dma_rvalid = rd_owner_r[1];
  assign cpu_do     = sram_DO;
  assign dma_do     = sram_DO;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed cycles push expected grants/port values
// and read data; a negedge monitor pops and compares. Honours SRAM_ARB_STARVE_EN.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_di, cpu_do;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr;
  logic [31:0] dma_di, dma_do;
  logic [15:0] sram_ADDR;
  logic [31:0] sram_DI, sram_DO;
  logic        sram_EN, sram_WE;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_BURST(8), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_do(cpu_do),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_di(dma_di), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_do(dma_do),
    .sram_ADDR(sram_ADDR), .sram_DI(sram_DI), .sram_EN(sram_EN), .sram_WE(sram_WE),
    .sram_DO(sram_DO)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (sram_EN) begin
      if (sram_WE) mem[sram_ADDR[7:0]] <= sram_DI;
      else         sram_DO <= mem[sram_ADDR[7:0]];
    end
  end

  typedef struct packed {
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [31:0] di;
  } exp_t;

  typedef struct packed {
    logic [1:0]  owner;
    logic [31:0] data;
  } rd_t;

  exp_t        exp_q [$];
  rd_t         rd_q  [$];
  logic [31:0] ref_mem [0:255];
  logic [1:0]  prev_rd = 2'b00;
  logic        done = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  localparam logic [1:0] G0 = 2'b00;
  localparam logic [1:0] GC = 2'b01;
  localparam logic [1:0] GD = 2'b10;

  task automatic cyc(input logic rst, input logic cr, input logic cw, input logic [15:0] ca,
                     input logic [31:0] cd, input logic dr, input logic dw, input logic dl,
                     input logic [15:0] da, input logic [31:0] dd, input logic [1:0] eg);
    exp_t e;
    @(posedge clk); #1;
    reset = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_di = cd;
    dma_req = dr; dma_we = dw; dma_lock = dl; dma_addr = da; dma_di = dd;
    e.gnt = eg; e.rv = prev_rd; e.en = (eg != G0);
    e.we = 1'b0; e.addr = 16'h0000; e.di = 32'h0000_0000;
    if (eg == GC) begin e.we = cw; e.addr = ca; e.di = cd; end
    else if (eg == GD) begin e.we = dw; e.addr = da; e.di = dd; end
    exp_q.push_back(e);
    if (e.en && e.we) ref_mem[e.addr[7:0]] = e.di;
    if (e.en && !e.we) rd_q.push_back({eg, ref_mem[e.addr[7:0]]});
    prev_rd = (e.en && !e.we) ? eg : 2'b00;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, G0);
  endtask

  // Scoreboard monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    rd_t  r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({dma_gnt, cpu_gnt} !== e.gnt || {dma_rvalid, cpu_rvalid} !== e.rv) begin
        n_fail++;
        $display("FAIL gnt_rvalid t=%0t: got gnt=%b rv=%b, want gnt=%b rv=%b",
                 $time, {dma_gnt, cpu_gnt}, {dma_rvalid, cpu_rvalid}, e.gnt, e.rv);
      end
      n_tests++;
      if ({sram_EN, sram_WE, sram_ADDR, sram_DI} !== {e.en, e.we, e.addr, e.di}) begin
        n_fail++;
        $display("FAIL sram_port t=%0t: got en=%b we=%b a=%h d=%h, want en=%b we=%b a=%h d=%h",
                 $time, sram_EN, sram_WE, sram_ADDR, sram_DI, e.en, e.we, e.addr, e.di);
      end
    end
    if (cpu_rvalid || dma_rvalid) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rdata t=%0t: unexpected rvalid=%b, want none", $time, {dma_rvalid, cpu_rvalid});
      end else begin
        r = rd_q.pop_front();
        if ({dma_rvalid, cpu_rvalid} !== r.owner || cpu_do !== r.data || dma_do !== r.data) begin
          n_fail++;
          $display("FAIL rdata t=%0t: got rv=%b cpu_do=%h dma_do=%h, want rv=%b data=%h",
                   $time, {dma_rvalid, cpu_rvalid}, cpu_do, dma_do, r.owner, r.data);
        end
      end
    end
    if (done) begin
      n_tests++;
      if (exp_q.size() != 0 || rd_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d/%0d pending, want 0/0", exp_q.size(), rd_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0000_0000;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_di = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = 16'h0; dma_di = 32'h0;
    repeat (2) @(posedge clk);

    // Reset held with both requesting: no grants, no rvalid.
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0, G0);

    // Preload via both writers, then single-requester reads.
    cyc(1'b0, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, GC);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0020, 32'hCAFE_0020, GD);
    cyc(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, GC);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0, GD);

    // Contention: CTL first, then the waiting DMA.
    cyc(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0, GC);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0, GD);
    idle();

    // Both held unlocked for 10 cycles.
    for (int i = 0; i < 10; i++) begin
`ifdef SRAM_ARB_STARVE_EN
      cyc(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0, (i % 5 == 4) ? GD : GC);
`else
      cyc(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0, GC);
`endif
    end
    idle();

    // Locked burst of MAX_BURST, cooldown grant to CTL, new burst.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, (i >= 2 && i <= 8), 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h0,
          (i == 8) ? GC : GD);
    end
    repeat (3) idle();

    // Lock dropped after 3 grants: CTL same cycle, cooldown, then IDLE priority.
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h0, GD);
    cyc(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h0, GD);
    cyc(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h0, GD);
    cyc(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'h0, GC);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h0, GD);
    cyc(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h0, GC);
    repeat (2) idle();

    // Reset in the middle of a burst on a DMA read request.
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h0, GD);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b1, 1'b1, 16'h0030, 32'h1357_9BDF, GD);
    cyc(1'b1, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0030, 32'h0, G0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0030, 32'h0, GC);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b1, 16'h0030, 32'h0, GD);
    repeat (3) idle();

    @(posedge clk); #1;
    done = 1'b1;
  end

endmodule
